// File: rtl/lenet_img_pkg.sv
// Shared types and default sizing for the LeNet5 image sink path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lenet_img_pkg;

    // Capture FSM states of the image writer.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } img_state_t;

    localparam int NUMPIXELS_DEF  = 1024;
    localparam int PIXELWIDTH_DEF = 8;
    localparam int ADDRWIDTH_DEF  = 10;

endpackage

// File: rtl/image_writer_frame_buffer_ram.sv
// Frame buffer: simple dual-port RAM, one write port, one synchronous read port.
// Latency: read data registered, one cycle after rd_addr; read-before-write on collision.
// Backpressure: none; a write or read is accepted every cycle.
module frame_buffer_ram #(
    parameter int DEPTH      = 1024,
    parameter int PIXELWIDTH = 8,
    parameter int ADDRWIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDRWIDTH-1:0]  wr_addr,
    input  logic [PIXELWIDTH-1:0] wr_data,
    input  logic [ADDRWIDTH-1:0]  rd_addr,
    output logic [PIXELWIDTH-1:0] rd_data
);

    // Index width just large enough for DEPTH entries.
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRWIDTH:0] DEPTH_W = (ADDRWIDTH+1)'(DEPTH);

    logic [PIXELWIDTH-1:0] mem [0:DEPTH-1];
    logic [PIXELWIDTH-1:0] rd_data_d;
    logic [PIXELWIDTH-1:0] rd_data_q;
    logic                  rd_in_range;

    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

    // Storage write; contents survive reset so a partial frame stays readable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[IDXW-1:0]] <= wr_data;
        end
    end

    // Read mux: addresses beyond the frame read as zero.
    always_comb begin
        rd_data_d = '0;
        if (rd_in_range) begin
            rd_data_d = mem[rd_addr[IDXW-1:0]];
        end
    end

    // Output register; sampling before the write lands gives read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/image_writer.sv
// Image writer: captures a valid/ready pixel stream into a frame buffer, flags frame completion.
// Latency: pixel written on the accepting edge; frame_done the cycle after the last transfer; rd_data 1 cycle.
// Backpressure: pixel_ready high only while capturing; pixels offered otherwise are dropped and flagged in drop_err.
module image_writer
    import lenet_img_pkg::*;
#(
    parameter int NUMPIXELS  = NUMPIXELS_DEF,
    parameter int PIXELWIDTH = PIXELWIDTH_DEF,
    parameter int ADDRWIDTH  = ADDRWIDTH_DEF,
    parameter     FILE       = "image_out.list"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PIXELWIDTH-1:0] pixel_in,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    output logic                  frame_done,
    output logic [ADDRWIDTH:0]    pixel_count,
    output logic                  drop_err,
    input  logic [ADDRWIDTH-1:0]  rd_addr,
    output logic [PIXELWIDTH-1:0] rd_data
);

    localparam logic [ADDRWIDTH-1:0] LAST_PTR = ADDRWIDTH'(NUMPIXELS - 1);

    img_state_t             state_d, state_q;
    logic [ADDRWIDTH-1:0]   ptr_d, ptr_q;
    logic [ADDRWIDTH:0]     cnt_d, cnt_q;
    logic                   drop_d, drop_q;
    logic                   xfer;

    // Next-state: start restarts from any state and beats both a transfer and a drop.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        xfer    = (state_q == ST_CAPTURE) && pixel_valid && !start;
        if (start) begin
            state_d = ST_CAPTURE;
            ptr_d   = '0;
            cnt_d   = '0;
            drop_d  = 1'b0;
        end else begin
            if (pixel_valid && (state_q != ST_CAPTURE)) begin
                drop_d = 1'b1;
            end
            if (xfer) begin
                ptr_d = ptr_q + ADDRWIDTH'(1);
                cnt_d = cnt_q + (ADDRWIDTH+1)'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_FULL;
                end
            end
        end
    end

    // State, pointer, count and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    assign pixel_ready = (state_q == ST_CAPTURE);
    assign frame_done  = (state_q == ST_FULL);
    assign pixel_count = cnt_q;
    assign drop_err    = drop_q;

    frame_buffer_ram #(
        .DEPTH      (NUMPIXELS),
        .PIXELWIDTH (PIXELWIDTH),
        .ADDRWIDTH  (ADDRWIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (xfer),
        .wr_addr (ptr_q),
        .wr_data (pixel_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
